// File: rtl/led_stretch_bank.sv
// Bank of front-panel LED pulse stretchers with per-channel mode, shared blink
// phase, lamp-test override and active-low registered drives.
module led_stretch_bank #(
    parameter int unsigned NCH         = 8,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned STRETCH_LEN = 10000000,
    parameter int unsigned PRE_W       = 22,
    parameter int unsigned BLINK_DIV   = 2500000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2*NCH-1:0] MODE,
    input  logic [NCH-1:0]   EVENT,
    input  logic             LAMP_TEST,
    output logic [NCH-1:0]   LED_L,
    output logic [NCH-1:0]   ACTIVE
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_STRETCH = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] LOAD     = CNT_W'(STRETCH_LEN);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

    // Parameter sanity: a bad build stops at elaboration.
    if (NCH < 1) begin : g_bad_nch
        $error("led_stretch_bank: NCH must be >= 1");
    end
    if (STRETCH_LEN < 1 || (CNT_W < 32 && (STRETCH_LEN >> CNT_W) != 0)) begin : g_bad_len
        $error("led_stretch_bank: STRETCH_LEN must be >= 1 and fit in CNT_W bits");
    end
    if (BLINK_DIV < 1 || (PRE_W < 32 && ((BLINK_DIV - 1) >> PRE_W) != 0)) begin : g_bad_div
        $error("led_stretch_bank: BLINK_DIV must be >= 1 and BLINK_DIV-1 fit in PRE_W bits");
    end

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             phase_q, phase_d;
    logic             pre_wrap;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]   on_c;
    logic [NCH-1:0]   led_l_q, led_l_d;
    logic [NCH-1:0]   active_q, active_d;

    // Shared free-running blink prescaler; phase flips on the wrap edge.
    always_comb begin
        pre_wrap = (pre_q == PRE_LAST);
        pre_d    = pre_wrap ? '0 : pre_q + PRE_W'(1);
        phase_d  = phase_q ^ pre_wrap;
    end

    // Per-channel stretch counter and LED decision from next-state values.
    always_comb begin
        on_c     = '0;
        led_l_d  = '1;
        active_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (EVENT[i]) begin
                cnt_d[i] = LOAD;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
                cnt_d[i] = '0;
            end

            case (mode_e'(MODE[2*i +: 2]))
                MODE_OFF:     on_c[i] = 1'b0;
                MODE_ON:      on_c[i] = 1'b1;
                MODE_STRETCH: on_c[i] = (cnt_d[i] != '0);
                MODE_BLINK:   on_c[i] = (cnt_d[i] != '0) && phase_d;
                default:      on_c[i] = 1'b0;
            endcase

            led_l_d[i]  = ~(on_c[i] | LAMP_TEST);
            active_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q    <= '0;
            phase_q  <= 1'b0;
            led_l_q  <= '1;
            active_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            phase_q  <= phase_d;
            led_l_q  <= led_l_d;
            active_q <= active_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign LED_L  = led_l_q;
    assign ACTIVE = active_q;

endmodule
